// File: rtl/perf_dump.sv
// perf_dump: snapshots N_CNT 64-bit performance counters on request and streams
// them out as 32-bit words over a valid/ready interface, low half first.
//
// Optional feature macro: PERF_DUMP_HEADER_EN. When defined, every dump is
// preceded by a header word 32'h50455246 with out_idx = 31.
//
// Ports
//   clock      : sole clock, rising edge
//   reset      : synchronous active-low reset
//   snap_req   : request a snapshot + dump (queued once if a dump is running)
//   cnt_in     : live counters, counter k at bits [64k+63:64k]
//   out_valid  : out_data/out_idx/out_last hold a word
//   out_ready  : consumer accepts the current word
//   out_data   : dump word
//   out_idx    : 2k = low half of counter k, 2k+1 = high half, 31 = header
//   out_last   : final word of the dump
//   busy       : dump in progress (SEND or DONE)
//   done       : one-cycle pulse after the final transfer
module perf_dump #(
  parameter int unsigned N_CNT = 9
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   snap_req,
  input  logic [64*N_CNT-1:0]    cnt_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic [4:0]             out_idx,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CW       = 64 * N_CNT;
  localparam int unsigned SW       = $clog2(CW);
  localparam logic [4:0]  LAST_IDX = 5'(2 * N_CNT - 1);
  localparam logic [4:0]  HDR_IDX  = 5'd31;
`ifdef PERF_DUMP_HEADER_EN
  localparam logic [31:0] HDR_WORD = 32'h5045_5246;
`endif

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic            pending;
  logic [CW-1:0]   snapshot;
  logic            start_c;
  logic            xfer_c;
  logic [4:0]      idx_next_c;
  logic [31:0]     word_next_c;

  // Next-state logic; out_valid is 1 throughout SEND, so out_ready alone marks a transfer
  always_comb begin
    state_next = state;
    start_c    = 1'b0;
    xfer_c     = 1'b0;
    case (state)
      IDLE: begin
        if (snap_req || pending) begin
          start_c    = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          xfer_c = 1'b1;
          if (out_last) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Following word: the header is always followed by word 0
  always_comb begin
    idx_next_c  = (out_idx == HDR_IDX) ? 5'd0 : out_idx + 5'd1;
    word_next_c = '0;
    if (idx_next_c <= LAST_IDX) begin
      word_next_c = snapshot[SW'({idx_next_c, 5'd0}) +: 32];
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Snapshot, pending flag and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      pending   <= 1'b0;
      snapshot  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);

      // One request can be queued while busy; extra ones are dropped
      if (start_c)                          pending <= 1'b0;
      else if (snap_req && (state != IDLE)) pending <= 1'b1;

      if (start_c) begin
        snapshot  <= cnt_in;
        out_valid <= 1'b1;
`ifdef PERF_DUMP_HEADER_EN
        out_idx   <= HDR_IDX;
        out_data  <= HDR_WORD;
`else
        out_idx   <= 5'd0;
        out_data  <= cnt_in[31:0];
`endif
        out_last  <= 1'b0;
      end else if (xfer_c) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          out_idx   <= idx_next_c;
          out_data  <= word_next_c;
          out_last  <= (idx_next_c == LAST_IDX);
        end
      end
    end
  end

endmodule

// File: tb/tb_perf_dump.sv
// tb_perf_dump: self-checking bench for perf_dump with N_CNT = 9.
// Expected dump contents come from a list-building model of the word order.
module tb_perf_dump;

  localparam int unsigned N  = 9;
  localparam int unsigned CW = 64 * N;
`ifdef PERF_DUMP_HEADER_EN
  localparam int unsigned HDR = 1;
`else
  localparam int unsigned HDR = 0;
`endif
  localparam int unsigned NW = 2 * N + HDR;

  logic          clock     = 1'b0;
  logic          reset     = 1'b0;
  logic          snap_req  = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] cnt_in    = '0;
  logic          out_valid;
  logic [31:0]   out_data;
  logic [4:0]    out_idx;
  logic          out_last;
  logic          busy;
  logic          done;

  perf_dump #(.N_CNT(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .snap_req (snap_req),
    .cnt_in   (cnt_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int bad    = 0;

  logic [31:0]   got_data[$];
  logic [4:0]    got_idx[$];
  logic          got_last[$];
  logic [31:0]   exp_data[$];
  logic [4:0]    exp_idx[$];
  logic          exp_last[$];
  int            rise_q[$];
  int            done_q[$];
  int            send_cyc;
  int            stall_cyc;
  int            stall_bad;
  logic [CW-1:0] cnt_at[int];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [CW-1:0] rand_cnt();
    logic [CW-1:0] v;
    for (int i = 0; i < int'(CW / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic exp_clear();
    exp_data.delete(); exp_idx.delete(); exp_last.delete();
  endtask

  // Reference: optional header, then counter k as (low, idx 2k), (high, idx 2k+1)
  task automatic model_dump(input logic [CW-1:0] v);
    logic [63:0] c;
`ifdef PERF_DUMP_HEADER_EN
    exp_data.push_back(32'h5045_5246); exp_idx.push_back(5'd31); exp_last.push_back(1'b0);
`endif
    for (int k = 0; k < int'(N); k++) begin
      c = v[64*k +: 64];
      exp_data.push_back(c[31:0]);  exp_idx.push_back(5'(2*k));     exp_last.push_back(1'b0);
      exp_data.push_back(c[63:32]); exp_idx.push_back(5'(2*k + 1)); exp_last.push_back(1'b0);
    end
    exp_last[exp_last.size() - 1] = 1'b1;
  endtask

  // Runs a fixed number of cycles, logging transfers, valid rises, done pulses and stalls
  task automatic collect(input bit toggle, input bit churn, input int n_extra, input int budget);
    int         start;
    logic       r;
    logic       stalled;
    logic       vprev;
    logic [38:0] held;
    start = cyc; r = 1'b1; stalled = 1'b0; vprev = out_valid; held = '0;
    cnt_at[cyc] = cnt_in;
    got_data.delete(); got_idx.delete(); got_last.delete();
    rise_q.delete(); done_q.delete();
    send_cyc = 0; stall_cyc = 0; stall_bad = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      snap_req = 1'b0;
      for (int j = 1; j <= n_extra; j++) if (cyc == start + 3*j + 1) snap_req = 1'b1;
      if (churn) cnt_in = rand_cnt();
      cnt_at[cyc] = cnt_in;
      if (out_valid && !vprev) rise_q.push_back(cyc);
      vprev = out_valid;
      if (done) done_q.push_back(cyc);
      if (busy && !done) send_cyc++;
      if (stalled && ({out_valid, out_data, out_idx, out_last} !== held)) stall_bad++;
      r = toggle ? ~r : 1'b1;
      out_ready = r;
      stalled = out_valid && !r;
      if (stalled) stall_cyc++;
      held = {out_valid, out_data, out_idx, out_last};
      if (out_valid && r) begin
        got_data.push_back(out_data); got_idx.push_back(out_idx); got_last.push_back(out_last);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; snap_req = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({out_valid, busy, done, out_last, out_idx, out_data} !== 40'h0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b b=%b d=%b l=%b idx=%0d data=%h exp all zero",
               out_valid, busy, done, out_last, out_idx, out_data);
    end
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({out_valid, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle got v=%b b=%b d=%b exp 000", out_valid, busy, done);
    end
  endtask

  task automatic test_basic();
    int req;
    for (int k = 0; k < int'(N); k++) cnt_in[64*k +: 64] = {32'(k), 32'h1000 + 32'(k)};
    exp_clear(); model_dump(cnt_in);
    snap_req = 1'b1; out_ready = 1'b1; req = cyc;
    collect(1'b0, 1'b0, 0, 30);
    checks++;
    if (rise_q.size() != 1 || rise_q[0] != req + 1) begin
      bad++; $display("FAIL basic_latency rises=%0d first=%0d exp one at %0d",
                      rise_q.size(), (rise_q.size() > 0) ? rise_q[0] : -1, req + 1);
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != req + 1 + int'(NW)) begin
      bad++; $display("FAIL basic_done pulses=%0d at=%0d exp one at %0d",
                      done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, req + 1 + int'(NW));
    end
    checks++;
    if (send_cyc != int'(NW)) begin
      bad++; $display("FAIL basic_send_cycles got=%0d exp=%0d", send_cyc, NW);
    end
    checks++;
    if (got_data.size() != int'(NW)) begin
      bad++; $display("FAIL basic_count got=%0d exp=%0d", got_data.size(), NW);
    end else begin
      checks++;
      if (got_data[HDR+2] !== 32'h0000_1001 || got_data[HDR+3] !== 32'h0000_0001) begin
        bad++; $display("FAIL basic_word23 got=%h,%h exp=00001001,00000001",
                        got_data[HDR+2], got_data[HDR+3]);
      end
      checks++;
      if (got_idx[NW-1] !== 5'd17 || got_last[NW-1] !== 1'b1) begin
        bad++; $display("FAIL basic_last idx=%0d last=%b exp 17/1", got_idx[NW-1], got_last[NW-1]);
      end
`ifdef PERF_DUMP_HEADER_EN
      checks++;
      if (got_data[0] !== 32'h5045_5246 || got_idx[0] !== 5'd31) begin
        bad++; $display("FAIL basic_header got=%h/%0d exp=50455246/31", got_data[0], got_idx[0]);
      end
`endif
      for (int i = 0; i < int'(NW); i++) begin
        checks++;
        if ({got_data[i], got_idx[i], got_last[i]} !== {exp_data[i], exp_idx[i], exp_last[i]}) begin
          bad++; $display("FAIL basic_word%0d got=%h/%0d/%b exp=%h/%0d/%b", i, got_data[i],
                          got_idx[i], got_last[i], exp_data[i], exp_idx[i], exp_last[i]);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL basic_idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_backpressure();
    cnt_in = rand_cnt();
    exp_clear(); model_dump(cnt_in);
    snap_req = 1'b1;
    collect(1'b1, 1'b0, 0, 60);
    checks++;
    if (send_cyc != 2 * int'(NW)) begin
      bad++; $display("FAIL bp_send_cycles got=%0d exp=%0d", send_cyc, 2 * NW);
    end
    checks++;
    if (stall_bad != 0 || stall_cyc != int'(NW)) begin
      bad++; $display("FAIL bp_stall unstable=%0d stalls=%0d exp 0/%0d", stall_bad, stall_cyc, NW);
    end
    checks++;
    if (done_q.size() != 1) begin
      bad++; $display("FAIL bp_done pulses=%0d exp=1", done_q.size());
    end
    checks++;
    if (got_data.size() != exp_data.size()) begin
      bad++; $display("FAIL bp_count got=%0d exp=%0d", got_data.size(), exp_data.size());
    end else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        checks++;
        if ({got_data[i], got_idx[i], got_last[i]} !== {exp_data[i], exp_idx[i], exp_last[i]}) begin
          bad++; $display("FAIL bp_word%0d got=%h/%0d/%b exp=%h/%0d/%b", i, got_data[i],
                          got_idx[i], got_last[i], exp_data[i], exp_idx[i], exp_last[i]);
        end
      end
    end
  endtask

  task automatic test_isolation();
    int req;
    cnt_in = rand_cnt();
    exp_clear(); model_dump(cnt_in);
    snap_req = 1'b1; out_ready = 1'b1; req = cyc;
    collect(1'b0, 1'b1, 0, 30);
    checks++;
    if (rise_q.size() != 1 || rise_q[0] != req + 1) begin
      bad++; $display("FAIL iso_latency rises=%0d exp one at %0d", rise_q.size(), req + 1);
    end
    checks++;
    if (got_data.size() != exp_data.size()) begin
      bad++; $display("FAIL iso_count got=%0d exp=%0d", got_data.size(), exp_data.size());
    end else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        checks++;
        if ({got_data[i], got_idx[i], got_last[i]} !== {exp_data[i], exp_idx[i], exp_last[i]}) begin
          bad++; $display("FAIL iso_word%0d got=%h/%0d/%b exp=%h/%0d/%b", i, got_data[i],
                          got_idx[i], got_last[i], exp_data[i], exp_idx[i], exp_last[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] v0;
    v0 = rand_cnt();
    cnt_in = v0;
    snap_req = 1'b1; out_ready = 1'b1;
    collect(1'b0, 1'b1, 3, 70);
    checks++;
    if (rise_q.size() != 2 || done_q.size() != 2) begin
      bad++; $display("FAIL b2b_dumps rises=%0d dones=%0d exp 2/2", rise_q.size(), done_q.size());
    end else begin
      checks++;
      if (rise_q[1] - done_q[0] != 2) begin
        bad++; $display("FAIL b2b_gap got=%0d exp=2", rise_q[1] - done_q[0]);
      end
      exp_clear(); model_dump(v0); model_dump(cnt_at[rise_q[1] - 1]);
      checks++;
      if (got_data.size() != exp_data.size()) begin
        bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_data.size(), exp_data.size());
      end else begin
        for (int i = 0; i < exp_data.size(); i++) begin
          checks++;
          if ({got_data[i], got_idx[i], got_last[i]} !== {exp_data[i], exp_idx[i], exp_last[i]}) begin
            bad++; $display("FAIL b2b_word%0d got=%h/%0d/%b exp=%h/%0d/%b", i, got_data[i],
                            got_idx[i], got_last[i], exp_data[i], exp_idx[i], exp_last[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int   req;
    logic hit;
    cnt_in = rand_cnt();
    snap_req = 1'b1; out_ready = 1'b1; hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      tick();
      snap_req = 1'b0;
      if (out_valid && out_idx == 5'd5) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      bad++; $display("FAIL rstmid_word5 got=not seen exp=seen within 30 cycles");
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if ({out_valid, busy, done, out_last, out_idx, out_data} !== 40'h0) begin
      bad++; $display("FAIL rstmid_clear got v=%b b=%b idx=%0d data=%h exp all zero",
                      out_valid, busy, out_idx, out_data);
    end
    tick(); tick(); tick();
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      bad++; $display("FAIL rstmid_no_resume got v=%b b=%b exp 00", out_valid, busy);
    end
    cnt_in = rand_cnt();
    exp_clear(); model_dump(cnt_in);
    snap_req = 1'b1; req = cyc;
    collect(1'b0, 1'b0, 0, 30);
    checks++;
    if (rise_q.size() != 1 || rise_q[0] != req + 1) begin
      bad++; $display("FAIL rstmid_restart_latency rises=%0d exp one at %0d", rise_q.size(), req + 1);
    end
    checks++;
    if (got_data.size() != exp_data.size()) begin
      bad++; $display("FAIL rstmid_count got=%0d exp=%0d", got_data.size(), exp_data.size());
    end else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        checks++;
        if ({got_data[i], got_idx[i], got_last[i]} !== {exp_data[i], exp_idx[i], exp_last[i]}) begin
          bad++; $display("FAIL rstmid_word%0d got=%h/%0d/%b exp=%h/%0d/%b", i, got_data[i],
                          got_idx[i], got_last[i], exp_data[i], exp_idx[i], exp_last[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_isolation();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
